// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: widths, phase codes, complex word type and
// the sign-extend / saturate helpers used by every butterfly stage.
package fft_pkg;

   localparam int DATA_W  = 14;
   localparam int TW_W    = 8;
   localparam int TW_FRAC = 6;
   localparam int FULL_W  = DATA_W + TW_W + 1;

   localparam logic [1:0] IDLE    = 2'b00;
   localparam logic [1:0] FIRST   = 2'b01;
   localparam logic [1:0] SECOND  = 2'b10;
   localparam logic [1:0] WAITING = 2'b11;

   localparam logic signed [FULL_W-1:0] SAT_MAX = FULL_W'((1 <<< (DATA_W - 1)) - 1);
   localparam logic signed [FULL_W-1:0] SAT_MIN = -FULL_W'(1 <<< (DATA_W - 1));

   typedef struct packed {
      logic signed [DATA_W-1:0] re;
      logic signed [DATA_W-1:0] im;
   } cplx_t;

   function automatic logic signed [FULL_W-1:0] sext(input logic signed [DATA_W-1:0] x);
      return {{(FULL_W - DATA_W){x[DATA_W-1]}}, x};
   endfunction

   function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [FULL_W-1:0] x);
      if (x > SAT_MAX) return SAT_MAX[DATA_W-1:0];
      if (x < SAT_MIN) return SAT_MIN[DATA_W-1:0];
      return x[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/bf_sdf8_if.sv
// Sample/phase/twiddle bus between the stage-2 controller and the butterfly,
// plus the result bus toward the stage-3 controller.
interface bf_sdf8_if;
   import fft_pkg::*;

   logic                     valid_i;
   logic [1:0]               state;
   logic signed [DATA_W-1:0] data_in_r;
   logic signed [DATA_W-1:0] data_in_i;
   logic signed [TW_W-1:0]   WN_r;
   logic signed [TW_W-1:0]   WN_i;
   logic                     valid_o;
   logic signed [DATA_W-1:0] data_out_r;
   logic signed [DATA_W-1:0] data_out_i;

   modport master (
      output valid_i, state, data_in_r, data_in_i, WN_r, WN_i,
      input  valid_o, data_out_r, data_out_i
   );

   modport slave (
      input  valid_i, state, data_in_r, data_in_i, WN_r, WN_i,
      output valid_o, data_out_r, data_out_i
   );

endinterface

// File: rtl/cmult_sat.sv
// Combinational complex multiply by a Q2.6 twiddle: full-precision products,
// arithmetic right shift by TW_FRAC (floor), then saturation to DATA_W.
module cmult_sat
   import fft_pkg::*;
(
   input  cplx_t                  b,
   input  logic signed [TW_W-1:0] wr,
   input  logic signed [TW_W-1:0] wi,
   output cplx_t                  p
);

   logic signed [FULL_W-1:0] br_x, bi_x, wr_x, wi_x;
   logic signed [FULL_W-1:0] full_r, full_i;

   always_comb begin
      br_x   = sext(b.re);
      bi_x   = sext(b.im);
      wr_x   = {{(FULL_W - TW_W){wr[TW_W-1]}}, wr};
      wi_x   = {{(FULL_W - TW_W){wi[TW_W-1]}}, wi};
      full_r = br_x * wr_x - bi_x * wi_x;
      full_i = br_x * wi_x + bi_x * wr_x;
      p.re   = sat_data(full_r >>> TW_FRAC);
      p.im   = sat_data(full_i >>> TW_FRAC);
   end

endmodule

// File: rtl/bf_sdf8.sv
// Radix-2 SDF butterfly for FFT stage 2: 8-deep feedback register, sum half
// emitted in FIRST, twiddled difference half emitted in SECOND.
module bf_sdf8
   import fft_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic     clk,
   input  logic     rst,
   bf_sdf8_if.slave bus
);

   cplx_t sr_q [DEPTH];
   cplx_t sr_d [DEPTH];
   cplx_t a, b, sum, diff, sr_in, cm;
   cplx_t out_d, out_q;
   logic  valid_d, valid_q;

   cmult_sat u_cmult (
      .b  (b),
      .wr (bus.WN_r),
      .wi (bus.WN_i),
      .p  (cm)
   );

   always_comb begin
      a.re    = bus.data_in_r;
      a.im    = bus.data_in_i;
      b       = sr_q[DEPTH-1];
      sum.re  = sat_data(sext(a.re) + sext(b.re));
      sum.im  = sat_data(sext(a.im) + sext(b.im));
      diff.re = sat_data(sext(b.re) - sext(a.re));
      diff.im = sat_data(sext(b.im) - sext(a.im));

      // FIRST parks the difference for the SECOND pass; other phases load raw samples
      sr_in = (bus.state == FIRST) ? diff : a;

      sr_d = sr_q;
      if (bus.state != IDLE) begin
         sr_d[0] = sr_in;
         for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
      end

      case (bus.state)
         FIRST:   out_d = sum;
         SECOND:  out_d = cm;
         default: out_d = '0;
      endcase

      valid_d = bus.valid_i && ((bus.state == FIRST) || (bus.state == SECOND));
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q <= 1'b0;
         out_q   <= '0;
         for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
      end else begin
         valid_q <= valid_d;
         out_q   <= out_d;
         sr_q    <= sr_d;
      end
   end

   assign bus.valid_o    = valid_q;
   assign bus.data_out_r = out_q.re;
   assign bus.data_out_i = out_q.im;

endmodule
